// File: rtl/inst_pipe_reg.sv
// Instruction pipeline register chain (IF/ID .. MEM/WB) with stall, flush and halt/drain control.
// Optional performance counters are built only when INST_PIPE_PERF_CNT_EN is defined.
module inst_pipe_reg (
  input  logic        in_CLK,
  input  logic        in_RST_N,
  input  logic [31:0] in_IR,
  input  logic        in_IR_VALID,
  input  logic        in_WE,
  input  logic        in_STALL_N,
  input  logic        in_FLUSH,
  input  logic        in_HALT_REQ,
  input  logic        in_RESUME,
  output logic [31:0] out_IS,
  output logic [31:0] out_PIS,
  output logic [31:0] out_PPIS,
  output logic [31:0] out_PPPIS,
  output logic        out_PWE,
  output logic        out_PPWE,
  output logic        out_PPPWE,
  output logic        out_PC_EN,
  output logic        out_BUBBLE,
  output logic        out_HALTED,
  output logic [15:0] out_STALL_CNT,
  output logic [15:0] out_FLUSH_CNT,
  output logic [31:0] out_RETIRE_CNT,
  output logic [1:0]  out_DBG_STATE
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic        halted_q;
  logic [31:0] is_q, pis_q, ppis_q, pppis_q;
  logic [31:0] is_d, pis_d, ppis_d, pppis_d;
  logic        pwe_q, ppwe_q, pppwe_q;
  logic        pwe_d, ppwe_d, pppwe_d;
  logic        st_run, st_drain, st_halted, flush_ok;

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_q  <= S_RUN;
      drain_q  <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == S_HALTED);
    end
  end

  // The drain counter only advances on non-stalled cycles so that four real
  // pipeline shifts empty the chain before the block parks in HALTED.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_RUN: begin
        if (in_HALT_REQ) begin
          state_d = S_DRAIN;
          drain_d = 3'd4;
        end
      end
      S_DRAIN: begin
        if (in_STALL_N) begin
          drain_d = drain_q - 3'd1;
          if (drain_q == 3'd1) state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (in_RESUME) state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
        drain_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    st_run        = (state_q == S_RUN);
    st_drain      = (state_q == S_DRAIN);
    st_halted     = (state_q == S_HALTED);
    flush_ok      = in_FLUSH && in_STALL_N && !st_halted;
    out_PC_EN     = in_STALL_N && st_run;
    out_BUBBLE    = !in_STALL_N && !st_halted;
    out_HALTED    = halted_q;
    out_DBG_STATE = state_q;
  end

  always_comb begin
    is_d    = is_q;
    pis_d   = pis_q;
    ppis_d  = ppis_q;
    pppis_d = pppis_q;
    pwe_d   = pwe_q;
    ppwe_d  = ppwe_q;
    pppwe_d = pppwe_q;
    if (!st_halted) begin
      pppis_d = ppis_q;
      pppwe_d = ppwe_q;
      ppis_d  = pis_q;
      ppwe_d  = pwe_q;
      if (!in_STALL_N) begin
        pis_d = 32'd0;
        pwe_d = 1'b0;
      end else begin
        pis_d = is_q;
        pwe_d = in_WE;
        if (in_FLUSH || st_drain) is_d = 32'd0;
        else                      is_d = in_IR_VALID ? in_IR : 32'd0;
      end
    end
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      is_q    <= 32'd0;
      pis_q   <= 32'd0;
      ppis_q  <= 32'd0;
      pppis_q <= 32'd0;
      pwe_q   <= 1'b0;
      ppwe_q  <= 1'b0;
      pppwe_q <= 1'b0;
    end else begin
      is_q    <= is_d;
      pis_q   <= pis_d;
      ppis_q  <= ppis_d;
      pppis_q <= pppis_d;
      pwe_q   <= pwe_d;
      ppwe_q  <= ppwe_d;
      pppwe_q <= pppwe_d;
    end
  end

  assign out_IS    = is_q;
  assign out_PIS   = pis_q;
  assign out_PPIS  = ppis_q;
  assign out_PPPIS = pppis_q;
  assign out_PWE   = pwe_q;
  assign out_PPWE  = ppwe_q;
  assign out_PPPWE = pppwe_q;

`ifdef INST_PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Stall and flush counters saturate; the retire counter wraps.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (!in_STALL_N && !st_halted && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_ok && flush_cnt_q != 16'hFFFF)                  flush_cnt_d = flush_cnt_q + 16'd1;
    if (!st_halted && pppis_q != 32'd0)                       retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign out_STALL_CNT  = stall_cnt_q;
  assign out_FLUSH_CNT  = flush_cnt_q;
  assign out_RETIRE_CNT = retire_cnt_q;
`else
  logic unused_flush_ok;
  assign unused_flush_ok = flush_ok;
  assign out_STALL_CNT   = 16'd0;
  assign out_FLUSH_CNT   = 16'd0;
  assign out_RETIRE_CNT  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_pipe_reg.sv
// Directed bench for inst_pipe_reg: streaming, stall, flush, halt/drain/resume and reset.
module tb_inst_pipe_reg;

`ifdef INST_PIPE_PERF_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        ir_valid = 1'b0, we = 1'b0, stall_n = 1'b1, flush = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] is_w, pis_w, ppis_w, pppis_w, retire_cnt;
  logic        pwe, ppwe, pppwe, pc_en, bubble, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  dbg_state;
  int          pass_cnt = 0, chk_cnt = 0;

  inst_pipe_reg dut (
    .in_CLK(clk), .in_RST_N(rst_n), .in_IR(ir), .in_IR_VALID(ir_valid), .in_WE(we),
    .in_STALL_N(stall_n), .in_FLUSH(flush), .in_HALT_REQ(halt_req), .in_RESUME(resume),
    .out_IS(is_w), .out_PIS(pis_w), .out_PPIS(ppis_w), .out_PPPIS(pppis_w),
    .out_PWE(pwe), .out_PPWE(ppwe), .out_PPPWE(pppwe), .out_PC_EN(pc_en),
    .out_BUBBLE(bubble), .out_HALTED(halted), .out_STALL_CNT(stall_cnt),
    .out_FLUSH_CNT(flush_cnt), .out_RETIRE_CNT(retire_cnt), .out_DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir = 32'd0; ir_valid = 1'b0; we = 1'b0; stall_n = 1'b1;
    flush = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] all_or;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    all_or = is_w | pis_w | ppis_w | pppis_w;
    chk_cnt++; if (all_or !== 32'd0) $display("FAIL reset_words: got %h exp 0", all_or); else pass_cnt++;
    chk_cnt++; if ({pwe, ppwe, pppwe} !== 3'b000) $display("FAIL reset_we: got %b exp 000", {pwe, ppwe, pppwe}); else pass_cnt++;
    chk_cnt++; if ({pc_en, bubble, halted} !== 3'b100) $display("FAIL reset_ctrl: got %b exp 100", {pc_en, bubble, halted}); else pass_cnt++;
    chk_cnt++; if ({stall_cnt, flush_cnt, retire_cnt} !== 64'd0) $display("FAIL reset_cnt: got %h exp 0", {stall_cnt, flush_cnt, retire_cnt}); else pass_cnt++;
    stall_n = 1'b0;
    #1;
    chk_cnt++; if ({pc_en, bubble} !== 2'b01) $display("FAIL reset_stall_ctrl: got %b exp 01", {pc_en, bubble}); else pass_cnt++;
    stall_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    logic [31:0] e_is [6], e_pis [6], e_ppis [6], e_pppis [6];
    words = '{32'h00221820, 32'h8C220004, 32'h00000000};
    e_is    = '{32'h00221820, 32'h8C220004, 32'h0, 32'h0, 32'h0, 32'h0};
    e_pis   = '{32'h0, 32'h00221820, 32'h8C220004, 32'h0, 32'h0, 32'h0};
    e_ppis  = '{32'h0, 32'h0, 32'h00221820, 32'h8C220004, 32'h0, 32'h0};
    e_pppis = '{32'h0, 32'h0, 32'h0, 32'h00221820, 32'h8C220004, 32'h0};
    do_reset();
    we = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ir       = (k < 3) ? words[k] : 32'd0;
      ir_valid = (k < 3);
      step();
      chk_cnt++; if (is_w !== e_is[k]) $display("FAIL stream_is[%0d]: got %h exp %h", k, is_w, e_is[k]); else pass_cnt++;
      chk_cnt++; if (pis_w !== e_pis[k]) $display("FAIL stream_pis[%0d]: got %h exp %h", k, pis_w, e_pis[k]); else pass_cnt++;
      chk_cnt++; if (ppis_w !== e_ppis[k]) $display("FAIL stream_ppis[%0d]: got %h exp %h", k, ppis_w, e_ppis[k]); else pass_cnt++;
      chk_cnt++; if (pppis_w !== e_pppis[k]) $display("FAIL stream_pppis[%0d]: got %h exp %h", k, pppis_w, e_pppis[k]); else pass_cnt++;
      if (k == 3) begin
        chk_cnt++; if (pppwe !== 1'b1) $display("FAIL stream_pppwe: got %b exp 1", pppwe); else pass_cnt++;
      end
    end
    chk_cnt++; if (retire_cnt !== 32'(2 * CNT_ON)) $display("FAIL stream_retire: got %0d exp %0d", retire_cnt, 2 * CNT_ON); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    we = 1'b1; ir_valid = 1'b1;
    ir = 32'h00221820; step();
    ir = 32'h00430820; step();
    chk_cnt++; if ({pis_w, pwe} !== {32'h00221820, 1'b1}) $display("FAIL stall_pre_pis: got %h/%b exp 00221820/1", pis_w, pwe); else pass_cnt++;
    stall_n = 1'b0; ir = 32'h11111111;
    #1;
    chk_cnt++; if ({pc_en, bubble} !== 2'b01) $display("FAIL stall_ctrl: got %b exp 01", {pc_en, bubble}); else pass_cnt++;
    step();
    chk_cnt++; if ({pis_w, pwe} !== 33'd0) $display("FAIL stall_pis: got %h/%b exp 0/0", pis_w, pwe); else pass_cnt++;
    chk_cnt++; if (is_w !== 32'h00430820) $display("FAIL stall_is_hold: got %h exp 00430820", is_w); else pass_cnt++;
    chk_cnt++; if (ppis_w !== 32'h00221820) $display("FAIL stall_ppis: got %h exp 00221820", ppis_w); else pass_cnt++;
    chk_cnt++; if (stall_cnt !== 16'(CNT_ON)) $display("FAIL stall_cnt: got %0d exp %0d", stall_cnt, CNT_ON); else pass_cnt++;
    stall_n = 1'b1; ir_valid = 1'b0;
    step();
    chk_cnt++; if ({is_w, pis_w} !== {32'h0, 32'h00430820}) $display("FAIL stall_release: got %h/%h exp 0/00430820", is_w, pis_w); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    ir = 32'h00430820; ir_valid = 1'b1;
    step();
    ir = 32'h22222222; flush = 1'b1; stall_n = 1'b0;
    step();
    chk_cnt++; if (is_w !== 32'h00430820) $display("FAIL flush_stalled_is: got %h exp 00430820", is_w); else pass_cnt++;
    chk_cnt++; if (flush_cnt !== 16'd0) $display("FAIL flush_stalled_cnt: got %0d exp 0", flush_cnt); else pass_cnt++;
    stall_n = 1'b1;
    step();
    chk_cnt++; if ({is_w, pis_w} !== {32'h0, 32'h00430820}) $display("FAIL flush_is: got %h/%h exp 0/00430820", is_w, pis_w); else pass_cnt++;
    chk_cnt++; if (flush_cnt !== 16'(CNT_ON)) $display("FAIL flush_cnt: got %0d exp %0d", flush_cnt, CNT_ON); else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    ir = 32'h00221820; ir_valid = 1'b1; halt_req = 1'b1;
    step();
    chk_cnt++; if ({dbg_state, is_w} !== {2'd1, 32'h00221820}) $display("FAIL halt_enter: got %0d/%h exp 1/00221820", dbg_state, is_w); else pass_cnt++;
    halt_req = 1'b0; resume = 1'b1; ir = 32'h33333333;
    step();
    chk_cnt++; if ({dbg_state, is_w, pis_w} !== {2'd1, 32'h0, 32'h00221820}) $display("FAIL halt_resume_ignored: got %0d/%h/%h exp 1/0/00221820", dbg_state, is_w, pis_w); else pass_cnt++;
    resume = 1'b0;
    step();
    step();
    chk_cnt++; if ({halted, pppis_w} !== {1'b0, 32'h00221820}) $display("FAIL halt_drain3: got %b/%h exp 0/00221820", halted, pppis_w); else pass_cnt++;
    step();
    chk_cnt++; if ({halted, dbg_state, pc_en} !== {1'b1, 2'd2, 1'b0}) $display("FAIL halt_halted: got %b/%0d/%b exp 1/2/0", halted, dbg_state, pc_en); else pass_cnt++;
    chk_cnt++; if ((is_w | pis_w | ppis_w | pppis_w) !== 32'd0) $display("FAIL halt_words: got %h exp 0", is_w | pis_w | ppis_w | pppis_w); else pass_cnt++;
    chk_cnt++; if (retire_cnt !== 32'(CNT_ON)) $display("FAIL halt_retire: got %0d exp %0d", retire_cnt, CNT_ON); else pass_cnt++;
    halt_req = 1'b1; ir = 32'h44444444;
    step();
    step();
    chk_cnt++; if ({halted, is_w} !== {1'b1, 32'h0}) $display("FAIL halt_hold: got %b/%h exp 1/0", halted, is_w); else pass_cnt++;
    halt_req = 1'b0; resume = 1'b1;
    step();
    chk_cnt++; if ({halted, dbg_state, pc_en, is_w} !== {1'b0, 2'd0, 1'b1, 32'h0}) $display("FAIL halt_resume: got %b/%0d/%b/%h exp 0/0/1/0", halted, dbg_state, pc_en, is_w); else pass_cnt++;
    resume = 1'b0;
    step();
    chk_cnt++; if (is_w !== 32'h44444444) $display("FAIL halt_refetch: got %h exp 44444444", is_w); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    ir = 32'h00221820; ir_valid = 1'b1; we = 1'b1; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    chk_cnt++; if ({dbg_state, pis_w} !== {2'd1, 32'h00221820}) $display("FAIL mid_drain_pre: got %0d/%h exp 1/00221820", dbg_state, pis_w); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ((is_w | pis_w | ppis_w | pppis_w) !== 32'd0) $display("FAIL mid_drain_words: got %h exp 0", is_w | pis_w | ppis_w | pppis_w); else pass_cnt++;
    chk_cnt++; if ({dbg_state, halted, pwe, pc_en} !== {2'd0, 1'b0, 1'b0, 1'b1}) $display("FAIL mid_drain_ctrl: got %0d/%b/%b/%b exp 0/0/0/1", dbg_state, halted, pwe, pc_en); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef INST_PIPE_PERF_CNT_EN
  task automatic test_stall_saturate();
    do_reset();
    stall_n = 1'b0;
    repeat (65535) step();
    chk_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h exp FFFF", stall_cnt); else pass_cnt++;
    step();
    chk_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h exp FFFF", stall_cnt); else pass_cnt++;
    stall_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_halt();
    test_reset_mid_drain();
`ifdef INST_PIPE_PERF_CNT_EN
    test_stall_saturate();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
